// File: rtl/wb_pkg.sv
// Shared Wishbone widths, arbiter state and grant encodings.
package wb_pkg;

   localparam int WB_DW = 32;
   localparam int WB_AW = 32;
   localparam int WB_SW = 4;

   typedef enum logic {
      IDLE,
      BUSY
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way round-robin picker: a tie goes to the master not served last.
module wb_rr_pick
   import wb_pkg::*;
(
   input  logic [1:0] req,
   input  logic [1:0] last_gnt,
   output logic [1:0] next_gnt
);

   always_comb begin
      next_gnt = GNT_NONE;
      unique case (1'b1)
         (req == 2'b11) && (last_gnt == GNT_M0): next_gnt = GNT_M1;
         (req == 2'b11) && (last_gnt != GNT_M0): next_gnt = GNT_M0;
         (req == 2'b01):                         next_gnt = GNT_M0;
         (req == 2'b10):                         next_gnt = GNT_M1;
         default:                                next_gnt = GNT_NONE;
      endcase
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter with registered round-robin grant
// and a watchdog that errors out transactions never acknowledged.
module wb_master_arbiter
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WB_DW-1:0] m0_wb_dat_i,
   input  logic [WB_AW-1:0] m0_wb_adr_i,
   input  logic [WB_SW-1:0] m0_wb_sel_i,
   input  logic             m0_wb_we_i,
   input  logic             m0_wb_cyc_i,
   input  logic             m0_wb_stb_i,
   output logic [WB_DW-1:0] m0_wb_dat_o,
   output logic             m0_wb_ack_o,
   output logic             m0_wb_err_o,
   input  logic [WB_DW-1:0] m1_wb_dat_i,
   input  logic [WB_AW-1:0] m1_wb_adr_i,
   input  logic [WB_SW-1:0] m1_wb_sel_i,
   input  logic             m1_wb_we_i,
   input  logic             m1_wb_cyc_i,
   input  logic             m1_wb_stb_i,
   output logic [WB_DW-1:0] m1_wb_dat_o,
   output logic             m1_wb_ack_o,
   output logic             m1_wb_err_o,
   output logic [WB_DW-1:0] s_wb_dat_o,
   output logic [WB_AW-1:0] s_wb_adr_o,
   output logic [WB_SW-1:0] s_wb_sel_o,
   output logic             s_wb_we_o,
   output logic             s_wb_cyc_o,
   output logic             s_wb_stb_o,
   input  logic [WB_DW-1:0] s_wb_dat_i,
   input  logic             s_wb_ack_i,
   output logic [1:0]       gnt_o
);

   arb_state_t      state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [1:0]      last_q, last_d;
   logic [1:0]      pick;
   logic [1:0]      req;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            busy, g_cyc;
   logic            ack_ev, to_ev, ab_ev, exit_ev;

   assign req = {m1_wb_cyc_i & m1_wb_stb_i,
                 m0_wb_cyc_i & m0_wb_stb_i};

   wb_rr_pick u_pick (
      .req      (req),
      .last_gnt (last_q),
      .next_gnt (pick)
   );

   assign busy  = (state_q == BUSY);
   assign g_cyc = gnt_q[1] ? m1_wb_cyc_i : m0_wb_cyc_i;

   // Exit causes are made exclusive here: ack, then timeout, then abort.
   assign ack_ev  = busy & s_wb_ack_i;
   assign to_ev   = busy & ~s_wb_ack_i &
                    (cnt_q == TO_W'(TIMEOUT - 1));
   assign ab_ev   = busy & ~s_wb_ack_i & ~to_ev & ~g_cyc;
   assign exit_ev = ack_ev | to_ev | ab_ev;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= GNT_NONE;
         last_q  <= GNT_M1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = BUSY;
               gnt_d   = pick;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (exit_ev) begin
               state_d = IDLE;
               gnt_d   = GNT_NONE;
               last_d  = gnt_q;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      s_wb_dat_o  = '0;
      s_wb_adr_o  = '0;
      s_wb_sel_o  = '0;
      s_wb_we_o   = 1'b0;
      s_wb_cyc_o  = 1'b0;
      s_wb_stb_o  = 1'b0;
      m0_wb_dat_o = '0;
      m0_wb_ack_o = 1'b0;
      m0_wb_err_o = 1'b0;
      m1_wb_dat_o = '0;
      m1_wb_ack_o = 1'b0;
      m1_wb_err_o = 1'b0;
      unique case (1'b1)
         gnt_q[0]: begin
            s_wb_dat_o  = m0_wb_dat_i;
            s_wb_adr_o  = m0_wb_adr_i;
            s_wb_sel_o  = m0_wb_sel_i;
            s_wb_we_o   = m0_wb_we_i;
            s_wb_cyc_o  = m0_wb_cyc_i & ~(to_ev | ab_ev);
            s_wb_stb_o  = m0_wb_stb_i & ~(to_ev | ab_ev);
            m0_wb_dat_o = s_wb_dat_i;
            m0_wb_ack_o = s_wb_ack_i;
            m0_wb_err_o = to_ev;
         end
         gnt_q[1]: begin
            s_wb_dat_o  = m1_wb_dat_i;
            s_wb_adr_o  = m1_wb_adr_i;
            s_wb_sel_o  = m1_wb_sel_i;
            s_wb_we_o   = m1_wb_we_i;
            s_wb_cyc_o  = m1_wb_cyc_i & ~(to_ev | ab_ev);
            s_wb_stb_o  = m1_wb_stb_i & ~(to_ev | ab_ev);
            m1_wb_dat_o = s_wb_dat_i;
            m1_wb_ack_o = s_wb_ack_i;
            m1_wb_err_o = to_ev;
         end
         default: begin
            s_wb_cyc_o = 1'b0;
         end
      endcase
   end

   assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Randomized bench for wb_master_arbiter with a transaction-level model.
module tb_wb_master_arbiter;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] m_adr[2];
   logic [31:0] m_wdat[2];
   logic [3:0]  m_sel[2];
   logic        m_we[2];
   logic        m_cyc[2];
   logic        m_stb[2];
   logic [31:0] m_rdat[2];
   logic        m_ack[2];
   logic        m_err[2];
   logic [31:0] s_dat_o, s_adr, s_dat_i;
   logic [3:0]  s_sel;
   logic        s_we, s_cyc, s_stb, s_ack;
   logic [1:0]  gnt;
   logic        done[2];

   int tests = 0;
   int fails = 0;

   wb_master_arbiter #(.TIMEOUT(TMO), .TO_W(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .m0_wb_dat_i (m_wdat[0]),
      .m0_wb_adr_i (m_adr[0]),
      .m0_wb_sel_i (m_sel[0]),
      .m0_wb_we_i  (m_we[0]),
      .m0_wb_cyc_i (m_cyc[0]),
      .m0_wb_stb_i (m_stb[0]),
      .m0_wb_dat_o (m_rdat[0]),
      .m0_wb_ack_o (m_ack[0]),
      .m0_wb_err_o (m_err[0]),
      .m1_wb_dat_i (m_wdat[1]),
      .m1_wb_adr_i (m_adr[1]),
      .m1_wb_sel_i (m_sel[1]),
      .m1_wb_we_i  (m_we[1]),
      .m1_wb_cyc_i (m_cyc[1]),
      .m1_wb_stb_i (m_stb[1]),
      .m1_wb_dat_o (m_rdat[1]),
      .m1_wb_ack_o (m_ack[1]),
      .m1_wb_err_o (m_err[1]),
      .s_wb_dat_o  (s_dat_o),
      .s_wb_adr_o  (s_adr),
      .s_wb_sel_o  (s_sel),
      .s_wb_we_o   (s_we),
      .s_wb_cyc_o  (s_cyc),
      .s_wb_stb_o  (s_stb),
      .s_wb_dat_i  (s_dat_i),
      .s_wb_ack_i  (s_ack),
      .gnt_o       (gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [31:0] adr,
                          input logic we);
      m_adr[k]  = adr;
      m_wdat[k] = $urandom;
      m_sel[k]  = 4'hF;
      m_we[k]   = we;
      m_cyc[k]  = 1'b1;
      m_stb[k]  = 1'b1;
   endtask

   task automatic drop_req(input int k);
      m_cyc[k] = 1'b0;
      m_stb[k] = 1'b0;
   endtask

   // Transaction-level model: who owns the bus, how long it has been
   // waiting, and who wins the next tie.
   initial begin : compare
      int owner;
      int ncyc;
      int prefer;
      logic [70:0] e_s;
      logic [33:0] e_m[2];
      logic [1:0]  e_g;
      logic tmo, abt, ack;
      owner  = -1;
      ncyc   = 0;
      prefer = 0;
      forever begin
         @(negedge clk);
         e_s = '0;
         e_m[0] = '0;
         e_m[1] = '0;
         e_g = 2'b00;
         if (rst) begin
            owner  = -1;
            prefer = 0;
         end else if (owner < 0) begin
            if (m_cyc[0] && m_stb[0] && m_cyc[1] && m_stb[1])
               owner = prefer;
            else if (m_cyc[0] && m_stb[0])
               owner = 0;
            else if (m_cyc[1] && m_stb[1])
               owner = 1;
            ncyc = 0;
         end else begin
            ack = s_ack;
            tmo = !ack && (ncyc == TMO - 1);
            abt = !ack && !tmo && !m_cyc[owner];
            e_g = (owner == 0) ? 2'b01 : 2'b10;
            e_s = {m_adr[owner], m_wdat[owner], m_sel[owner],
                   m_we[owner], m_cyc[owner] && !(tmo || abt),
                   m_stb[owner] && !(tmo || abt)};
            e_m[owner] = {s_dat_i, ack, tmo};
            if (ack || tmo || abt) begin
               prefer = 1 - owner;
               owner  = -1;
            end else begin
               ncyc++;
            end
         end
         chk("gnt", 128'(gnt), 128'(e_g));
         chk("s_bus", 128'({s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb}),
             128'(e_s));
         chk("m0_out", 128'({m_rdat[0], m_ack[0], m_err[0]}),
             128'(e_m[0]));
         chk("m1_out", 128'({m_rdat[1], m_ack[1], m_err[1]}),
             128'(e_m[1]));
         done[0] = m_ack[0] | m_err[0];
         done[1] = m_ack[1] | m_err[1];
      end
   end

   initial begin : stim
      int mode;
      for (int k = 0; k < 2; k++) begin
         m_adr[k] = '0; m_wdat[k] = '0; m_sel[k] = '0;
         m_we[k] = 1'b0; m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
         done[k] = 1'b0;
      end
      s_dat_i = '0;
      s_ack   = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 128'(gnt), 128'(0));
      chk("rst_scyc", 128'({s_cyc, s_stb}), 128'(0));
      rst = 1'b0;
      tick();

      // simultaneous requests from reset: 0,1,0,1
      set_req(0, 32'h0000_0100, 1'b0);
      set_req(1, 32'h0000_0200, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tie_gnt", 128'(gnt),
             128'(((i % 2) == 0) ? 2'b01 : 2'b10));
         s_ack = 1'b1;
         tick();
         s_ack = 1'b0;
         chk("tie_idle", 128'(gnt), 128'(0));
      end
      drop_req(0);
      drop_req(1);
      tick();

      // single M0 read
      set_req(0, 32'h0000_1004, 1'b0);
      tick();
      chk("rd_gnt", 128'(gnt), 128'(2'b01));
      chk("rd_adr", 128'(s_adr), 128'(32'h0000_1004));
      chk("rd_stb", 128'({s_cyc, s_stb}), 128'(2'b11));
      tick();
      tick();
      s_ack   = 1'b1;
      s_dat_i = 32'hA5A5_0001;
      #1;
      chk("rd_ack", 128'(m_ack[0]), 128'(1));
      chk("rd_dat", 128'(m_rdat[0]), 128'(32'hA5A5_0001));
      chk("rd_m1", 128'({m_rdat[1], m_ack[1], m_err[1]}), 128'(0));
      tick();
      s_ack = 1'b0;
      drop_req(0);
      chk("rd_idle", 128'(gnt), 128'(0));
      tick();

      // M1 write never acknowledged
      set_req(1, 32'h0000_2000, 1'b1);
      tick();
      for (int c = 0; c < TMO - 1; c++) begin
         chk("to_noerr", 128'({m_err[1], m_ack[1]}), 128'(0));
         chk("to_cyc", 128'(s_cyc), 128'(1));
         tick();
      end
      chk("to_err", 128'(m_err[1]), 128'(1));
      chk("to_noack", 128'(m_ack[1]), 128'(0));
      chk("to_cyc0", 128'({s_cyc, s_stb}), 128'(0));
      drop_req(1);
      tick();
      chk("to_idle", 128'(gnt), 128'(0));
      chk("to_erroff", 128'(m_err[1]), 128'(0));
      tick();

      // ack in the expiry cycle wins over timeout
      set_req(0, 32'h0000_3000, 1'b0);
      tick();
      for (int c = 0; c < TMO - 1; c++) tick();
      s_ack   = 1'b1;
      s_dat_i = 32'h1234_5678;
      #1;
      chk("ax_ack", 128'(m_ack[0]), 128'(1));
      chk("ax_noerr", 128'(m_err[0]), 128'(0));
      drop_req(0);
      tick();
      s_ack = 1'b0;
      tick();

      // abort with a pending M1 request
      set_req(0, 32'h0000_4000, 1'b0);
      tick();
      chk("ab_gnt0", 128'(gnt), 128'(2'b01));
      set_req(1, 32'h0000_5000, 1'b0);
      tick();
      drop_req(0);
      #1;
      chk("ab_cyc0", 128'({s_cyc, s_stb}), 128'(0));
      chk("ab_m0", 128'({m_ack[0], m_err[0]}), 128'(0));
      tick();
      chk("ab_idle", 128'(gnt), 128'(0));
      tick();
      chk("ab_gnt1", 128'(gnt), 128'(2'b10));
      chk("ab_adr1", 128'(s_adr), 128'(32'h0000_5000));
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      drop_req(1);
      tick();

      // reset while BUSY
      set_req(1, 32'h0000_6000, 1'b0);
      tick();
      chk("mr_gnt", 128'(gnt), 128'(2'b10));
      rst = 1'b1;
      #1;
      chk("mr_gnt0", 128'(gnt), 128'(0));
      chk("mr_sbus", 128'({s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb}),
          128'(0));
      chk("mr_m1", 128'({m_rdat[1], m_ack[1], m_err[1]}), 128'(0));
      set_req(0, 32'h0000_7000, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("mr_tie", 128'(gnt), 128'(2'b01));
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      drop_req(0);
      drop_req(1);
      tick();

      // randomized traffic
      mode = 0;
      for (int n = 0; n < 4000; n++) begin
         if ((n % 250) == 0) mode = $urandom_range(0, 2);
         for (int k = 0; k < 2; k++) begin
            if (m_cyc[k]) begin
               if (done[k] || ($urandom_range(0, 49) == 0))
                  drop_req(k);
            end else if ($urandom_range(0, 2) == 0) begin
               set_req(k, $urandom, 1'($urandom));
               m_sel[k] = 4'($urandom);
               m_stb[k] = ($urandom_range(0, 7) != 0);
            end
         end
         s_dat_i = $urandom;
         case (mode)
            0: s_ack = ($urandom_range(0, 2) == 0);
            1: s_ack = ($urandom_range(0, 9) == 0);
            default: s_ack = 1'b0;
         endcase
         if (n == 3000) rst = 1'b1;
         if (n == 3003) rst = 1'b0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
